// File: rtl/imm_ext_arbiter_pkg.sv
// Shared types for the immediate-extension arbiter: extend-mode encoding,
// the requester-ID width and the queue entry layout.
package imm_ext_pkg;

  localparam int ID_W   = 1;
  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_LUI  = 2'd2
  } ext_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } rsp_entry_t;

  // Upper-half placement wins over the zero/sign choice.
  function automatic ext_mode_e ext_mode(input logic is_unsigned, input logic lui);
    ext_mode_e m;
    if (lui)              m = EXT_LUI;
    else if (is_unsigned) m = EXT_ZERO;
    else                  m = EXT_SIGN;
    return m;
  endfunction

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle between the two immediate producers, the
// arbiter (slave side) and the result consumer (master side).
interface imm_ext_arbiter_if;
  import imm_ext_pkg::*;

  logic              req0_valid;
  logic [IMM_W-1:0]  req0_imm;
  logic              req0_unsigned;
  logic              req0_lui;
  logic              req0_ready;

  logic              req1_valid;
  logic [IMM_W-1:0]  req1_imm;
  logic              req1_unsigned;
  logic              req1_lui;
  logic              req1_ready;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_ready;

  modport master (
    output req0_valid, req0_imm, req0_unsigned, req0_lui,
    output req1_valid, req1_imm, req1_unsigned, req1_lui,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_imm, req0_unsigned, req0_lui,
    input  req1_valid, req1_imm, req1_unsigned, req1_lui,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/imm_ext_arbiter_rr_arb2.sv
// Two-way round-robin grant. The priority pointer moves to the loser after
// every grant and holds when nothing is granted.
module rr_arb2
  import imm_ext_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic            en,
  output logic [1:0]      gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = prio ? 2'b10 : 2'b01;
      else                  gnt = req;
    end
  end

  assign any_gnt = |gnt;
  assign gnt_id  = gnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= 1'b0;
    else if (any_gnt) prio <= ~gnt[1];
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Arbitrates two immediate producers, extends the granted immediate and
// queues the 32-bit result with its requester ID in a small FIFO.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  imm_ext_arbiter_if.slave  bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  rsp_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              full;
  logic              push_en;
  logic              push;
  logic              pop;
  logic [1:0]        gnt;
  logic [ID_W-1:0]   gnt_id;

  logic [IMM_W-1:0]  sel_imm;
  logic              sel_unsigned;
  logic              sel_lui;
  logic [DATA_W-1:0] ext_data;
  rsp_entry_t        new_entry;
  rsp_entry_t        head;

  // A full queue refuses even if it pops this cycle, so ready never sees rsp_ready.
  assign full    = (count == FULL_CNT);
  assign push_en = !full && !rst;
  assign pop     = bus.rsp_ready && (count != '0);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .en      (push_en),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (push)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    sel_imm      = bus.req0_imm;
    sel_unsigned = bus.req0_unsigned;
    sel_lui      = bus.req0_lui;
    if (gnt[1]) begin
      sel_imm      = bus.req1_imm;
      sel_unsigned = bus.req1_unsigned;
      sel_lui      = bus.req1_lui;
    end
  end

  always_comb begin
    ext_data = {{(DATA_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
    case (ext_mode(sel_unsigned, sel_lui))
      EXT_LUI:  ext_data = {sel_imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_ZERO: ext_data = {{(DATA_W-IMM_W){1'b0}}, sel_imm};
      default:  ext_data = {{(DATA_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
    endcase
  end

  always_comb begin
    new_entry.data = ext_data;
    new_entry.id   = gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents zeros rather than a stale slot.
  assign head          = mem[rd_ptr];
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_id    = bus.rsp_valid ? head.id   : '0;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter (DEPTH=2): extension modes, round-robin
// contention, backpressure, pointer wrap and asynchronous reset.
module tb_imm_ext_arbiter;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imm_ext_arbiter_if bus ();

  imm_ext_arbiter #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid    = 1'b0;
    bus.req0_imm      = 16'h0000;
    bus.req0_unsigned = 1'b0;
    bus.req0_lui      = 1'b0;
    bus.req1_valid    = 1'b0;
    bus.req1_imm      = 16'h0000;
    bus.req1_unsigned = 1'b0;
    bus.req1_lui      = 1'b0;
  endtask

  logic [31:0] want_data;

  initial begin
    // Reset with both requesters offering: nothing may be accepted.
    rst = 1'b1;
    idle();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    tick();
    tick();
    chk("rst_hold_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_req0_ready", bus.req0_ready, 0);
    chk("post_rst_rsp_valid", bus.rsp_valid, 0);

    // Single sign-extended push from requester 0.
    bus.req0_valid = 1'b1;
    bus.req0_imm   = 16'h8001;
    #1;
    chk("single_req0_ready", bus.req0_ready, 1);
    chk("single_req1_ready", bus.req1_ready, 0);
    tick();
    idle();
    #1;
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_data", bus.rsp_data, 32'hFFFF8001);
    chk("single_rsp_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("single_drained", bus.rsp_valid, 0);

    // Zero-extend then upper-half from requester 1, pop overlapping push.
    bus.req1_valid    = 1'b1;
    bus.req1_imm      = 16'h8001;
    bus.req1_unsigned = 1'b1;
    #1;
    chk("mode_req1_ready", bus.req1_ready, 1);
    tick();
    bus.req1_lui  = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("mode_zero_data", bus.rsp_data, 32'h00008001);
    chk("mode_zero_id", bus.rsp_id, 1);
    chk("mode_req1_ready2", bus.req1_ready, 1);
    tick();
    idle();
    #1;
    chk("mode_lui_valid", bus.rsp_valid, 1);
    chk("mode_lui_data", bus.rsp_data, 32'h80010000);
    chk("mode_lui_id", bus.rsp_id, 1);
    tick();
    chk("mode_drained", bus.rsp_valid, 0);

    // Contention: pointer is back at 0, so grants alternate 0,1,0,1.
    bus.req0_valid    = 1'b1;
    bus.req0_imm      = 16'h0010;
    bus.req1_valid    = 1'b1;
    bus.req1_imm      = 16'h0020;
    bus.req1_unsigned = 1'b1;
    bus.rsp_ready     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont_gnt0_%0d", k), bus.req0_ready, ((k % 2) == 0));
      chk($sformatf("cont_gnt1_%0d", k), bus.req1_ready, ((k % 2) == 1));
      if (k > 0) begin
        want_data = ((k - 1) % 2 == 1) ? 32'h00000020 : 32'h00000010;
        chk($sformatf("cont_id_%0d", k), bus.rsp_id, (k - 1) % 2);
        chk($sformatf("cont_data_%0d", k), bus.rsp_data, want_data);
      end
      tick();
    end
    idle();
    #1;
    chk("cont_last_id", bus.rsp_id, 1);
    chk("cont_last_data", bus.rsp_data, 32'h00000020);
    tick();
    chk("cont_drained", bus.rsp_valid, 0);

    // Backpressure: fill two, third offer refused even with a pop.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_imm   = 16'h0001;
    #1;
    chk("bp_push1_ready", bus.req0_ready, 1);
    tick();
    bus.req0_imm = 16'h0002;
    #1;
    chk("bp_push2_ready", bus.req0_ready, 1);
    tick();
    bus.req0_imm = 16'h0003;
    #1;
    chk("bp_full_ready", bus.req0_ready, 0);
    chk("bp_full_head", bus.rsp_data, 32'h00000001);
    tick();
    chk("bp_stable_data", bus.rsp_data, 32'h00000001);
    chk("bp_stable_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_full_pop_ready", bus.req0_ready, 0);
    tick();
    chk("bp_after_pop_head", bus.rsp_data, 32'h00000002);
    chk("bp_reopen_ready", bus.req0_ready, 1);
    tick();
    idle();
    #1;
    chk("bp_third_head", bus.rsp_data, 32'h00000003);
    tick();
    chk("bp_drained", bus.rsp_valid, 0);

    // Wrap: six pushes streaming against pops, alternating requesters.
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i % 2 == 1) begin
        bus.req1_valid = 1'b1;
        bus.req1_imm   = 16'h0100 + 16'(i);
        bus.req1_lui   = 1'b1;
      end else begin
        bus.req0_valid    = 1'b1;
        bus.req0_imm      = 16'h0100 + 16'(i);
        bus.req0_unsigned = 1'b1;
      end
      #1;
      chk($sformatf("wrap_ready_%0d", i), (i % 2 == 1) ? bus.req1_ready : bus.req0_ready, 1);
      if (i > 0) begin
        want_data = ((i - 1) % 2 == 1) ? {16'h0100 + 16'(i - 1), 16'h0000}
                                       : {16'h0000, 16'h0100 + 16'(i - 1)};
        chk($sformatf("wrap_data_%0d", i), bus.rsp_data, want_data);
        chk($sformatf("wrap_id_%0d", i), bus.rsp_id, (i - 1) % 2);
      end
      tick();
    end
    idle();
    #1;
    chk("wrap_last_data", bus.rsp_data, 32'h01050000);
    chk("wrap_last_id", bus.rsp_id, 1);
    tick();
    chk("wrap_drained", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b0;

    // Async reset with two entries queued and priority pointer at 1.
    bus.req0_valid = 1'b1;
    bus.req0_imm   = 16'h00AA;
    tick();
    bus.req0_imm = 16'h00BB;
    tick();
    idle();
    #1;
    chk("ar_pre_valid", bus.rsp_valid, 1);
    chk("ar_pre_data", bus.rsp_data, 32'h000000AA);
    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_imm   = 16'h0055;
    bus.req1_valid = 1'b1;
    bus.req1_imm   = 16'h0077;
    #1;
    chk("ar_valid_drop", bus.rsp_valid, 0);
    chk("ar_data_zero", bus.rsp_data, 32'h0);
    chk("ar_req0_ready", bus.req0_ready, 0);
    chk("ar_req1_ready", bus.req1_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_prio_req0", bus.req0_ready, 1);
    chk("ar_prio_req1", bus.req1_ready, 0);
    tick();
    idle();
    #1;
    chk("ar_first_id", bus.rsp_id, 0);
    chk("ar_first_data", bus.rsp_data, 32'h00000055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
